// File: rtl/fetch_buffer_if.sv
// ============================================================================
// fetch_buffer_if : I-cache request port and decode handshake of fetch_buffer
// Revision: 1.0
// ============================================================================
`default_nettype none

interface fetch_buffer_if #(
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic          instr_read;
  logic [31:0]   instr_mem_address;
  logic [31:0]   instr_mem_rdata;
  logic          instr_mem_resp;
  logic          fb_valid;
  logic [31:0]   fb_instr;
  logic [31:0]   fb_pc;
  logic          fb_ready;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic [CW-1:0] fb_count;

  modport master (
    output instr_read, instr_mem_address, fb_valid, fb_instr, fb_pc, fb_count,
    input  instr_mem_rdata, instr_mem_resp, fb_ready, redirect, redirect_pc
  );

  modport slave (
    input  instr_read, instr_mem_address, fb_valid, fb_instr, fb_pc, fb_count,
    output instr_mem_rdata, instr_mem_resp, fb_ready, redirect, redirect_pc
  );
endinterface

`default_nettype wire

// File: rtl/fetch_buffer.sv
// ============================================================================
// fetch_buffer : sequential I-fetch with PC-tagged FIFO and redirect flush
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic          clk,
  input  logic          reset_n,
  fetch_buffer_if.master bus
);

  localparam int            PW      = $clog2(DEPTH);
  localparam int            CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [63:0]   mem_q [DEPTH];
  logic [63:0]   head_entry;
  logic          push;
  logic          pop;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    push       = 1'b0;
    pop        = (count_q != '0) && bus.fb_ready;

    if (bus.redirect) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = bus.redirect_pc;
      case (state_q)
        IDLE: begin
          state_d    = REQ;
          req_addr_d = bus.redirect_pc;
        end
        REQ, DRAIN: begin
          // An unanswered request cannot be withdrawn; wait out its response.
          if (bus.instr_mem_resp) begin
            state_d    = REQ;
            req_addr_d = bus.redirect_pc;
          end else begin
            state_d = DRAIN;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      count_d = count_q - {{(CW-1){1'b0}}, pop};
      case (state_q)
        IDLE: begin
          // Post-pop occupancy lets a freed slot be refilled on the next cycle.
          if (count_d < DEPTH_C) begin
            state_d    = REQ;
            req_addr_d = fetch_pc_q;
          end
        end
        REQ: begin
          if (bus.instr_mem_resp) begin
            push       = 1'b1;
            tail_d     = tail_q + PW'(1);
            fetch_pc_d = req_addr_q + 32'd4;
            count_d    = count_d + CW'(1);
            if (count_d < DEPTH_C) begin
              req_addr_d = req_addr_q + 32'd4;
            end else begin
              state_d = IDLE;
            end
          end
        end
        DRAIN: begin
          if (bus.instr_mem_resp) begin
            state_d    = REQ;
            req_addr_d = fetch_pc_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: the head is only exposed while count is nonzero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= {req_addr_q, bus.instr_mem_rdata};
    end
  end

  assign head_entry            = mem_q[head_q];
  assign bus.instr_read        = (state_q != IDLE);
  assign bus.instr_mem_address = req_addr_q;
  assign bus.fb_valid          = (count_q != '0);
  assign bus.fb_pc             = bus.fb_valid ? head_entry[63:32] : 32'd0;
  assign bus.fb_instr          = bus.fb_valid ? head_entry[31:0]  : 32'd0;
  assign bus.fb_count          = count_q;

endmodule

`default_nettype wire
